mac_seq_ctrl: RTL

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl_pkg.sv | 27 ++
 rtl/mac_seq_tag_pipe.sv | 47 ++++
 rtl/mac_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC slice sequencer: FSM state encoding and
// the slice OPMODE constants used to load or accumulate into P.
package mac_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] OPMODE_LOAD = 8'h01;  // P = M
    localparam logic [7:0] OPMODE_ACC  = 8'h09;  // P = P + M
    localparam logic [7:0] OPMODE_IDLE = 8'h00;

    // OPMODE for a tag leaving the pipeline: the first beat loads P, later
    // beats accumulate, and an empty slot leaves P untouched.
    function automatic logic [7:0] opmode_sel(input logic valid, input logic first);
        if (!valid)
            return OPMODE_IDLE;
        else if (first)
            return OPMODE_LOAD;
        else
            return OPMODE_ACC;
    endfunction

endpackage

// File: rtl/mac_seq_tag_pipe.sv
// Tag shift register that follows each accepted beat through the slice so
// the M and P enables line up with the data. Each stage carries {valid, first}.
module mac_seq_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_push,
    input  logic i_first,
    output logic o_s1_valid,
    output logic o_last_valid,
    output logic o_last_first,
    output logic o_early_valid
);

    // Marks the final stage so the remaining stages can be OR-reduced.
    localparam logic [DEPTH-1:0] LAST_MASK = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_first;

    // Shift tags one stage per cycle; a synchronous clear flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_first <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
            r_first <= '0;
        end else begin
            r_valid[0] <= i_push;
            r_first[0] <= i_push & i_first;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_first[i] <= r_first[i-1];
            end
        end
    end

    assign o_s1_valid    = r_valid[0];
    assign o_last_valid  = r_valid[DEPTH-1];
    assign o_last_first  = r_first[DEPTH-1];
    // Any tag still in flight ahead of the last stage.
    assign o_early_valid = |(r_valid & ~LAST_MASK);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a pipelined MAC slice: accepts len operand beats, drives the
// A/B, M and P clock enables and OPMODE so P ends up holding the sum, then
// pulses done. Optional abort input is enabled by MAC_SEQ_CTRL_ABORT_EN.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready are
// both 1; in_ready is high exactly while in RUN and never depends on in_valid.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3   // legal 2..8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
`ifdef MAC_SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             in_ready,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic             rst_p,
    output logic [7:0]       opmode,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_clr;
    logic             w_rst_p;
    logic             w_load;
    logic             w_s1_valid;
    logic             w_last_valid;
    logic             w_last_first;
    logic             w_early_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode plus handshake, clear and done outputs.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        w_accept = 1'b0;
        w_clr    = 1'b0;
        w_rst_p  = 1'b0;
        w_load   = 1'b0;
        done     = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_load = 1'b1;
                        w_next = S_RUN;
                    end else begin
                        // Empty accumulation: clear P so it reads zero at done.
                        w_rst_p = 1'b1;
                        w_next  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (w_accept && (r_cnt == r_len - 1'b1))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Last tag leaving with nothing behind it is the final P update.
                if (w_last_valid && !w_early_valid)
                    w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
`ifdef MAC_SEQ_CTRL_ABORT_EN
        if (abort && (r_state != S_IDLE)) begin
            w_next  = S_IDLE;
            w_clr   = 1'b1;
            w_rst_p = 1'b1;
            done    = 1'b0;
        end
`endif
    end

    // Latch len at start and count accepted beats; the count peaks at len,
    // which always fits in LEN_W bits, so no wrap is possible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_len <= len;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    mac_seq_tag_pipe #(
        .DEPTH (PIPE_LAT - 1)
    ) u_tag_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_clr),
        .i_push        (w_accept),
        .i_first       (r_cnt == '0),
        .o_s1_valid    (w_s1_valid),
        .o_last_valid  (w_last_valid),
        .o_last_first  (w_last_first),
        .o_early_valid (w_early_valid)
    );

    assign ce_ab  = w_accept;
    assign ce_m   = w_s1_valid;
    assign ce_p   = w_last_valid;
    assign opmode = opmode_sel(w_last_valid, w_last_first);
    assign rst_p  = rst | w_rst_p;

endmodule
